// File: rtl/pid_scheduler_if.sv
// Error-fetch, datapath-step and output-capture signals of the PID scheduler.
// Latency: n/a (wiring only).
// Backpressure: err_req/err_valid fetch handshake; out_valid/out_ack capture handshake.
interface pid_scheduler_if #(
  parameter int aw = 1,
  parameter int ew = 24,
  parameter int ow = 12
);
  localparam int an = 2**aw;

  logic              err_req;
  logic              err_valid;
  logic [ew-1:0]     err_in;
  logic [ew-1:0]     err_out;
  logic [aw-1:0]     a;
  logic [3:0]        state;
  logic              calc;
  logic [ow-1:0]     m_in;
  logic [an*ow-1:0]  m_out;
  logic [an-1:0]     out_valid;
  logic [an-1:0]     out_ack;

  // scheduler side
  modport master (
    output err_req, err_out, a, state, calc, m_out, out_valid,
    input  err_valid, err_in, m_in, out_ack
  );

  // encoder/datapath/CPU side
  modport slave (
    input  err_req, err_out, a, state, calc, m_out, out_valid,
    output err_valid, err_in, m_in, out_ack
  );
endinterface

// File: rtl/pid_scheduler.sv
// Loop-period tick generator and per-channel sequencer for the shared PID datapath.
// Latency: REQ one clock after tick, first calc one clock after err_valid, capture one clock after state-8 strobe.
// Backpressure: waits up to tmo clocks for err_valid; unacked captures are overwritten and flag overrun.
module pid_scheduler #(
  parameter int aw  = 1,
  parameter int an  = 2**aw,
  parameter int psc = 15,
  parameter int sdw = 8,
  parameter int ew  = 24,
  parameter int ow  = 12,
  parameter int tmo = 255
) (
  input  logic            clk_pid,
  input  logic            reset,
  input  logic [psc-1:0]  period,
  input  logic [sdw-1:0]  step_div,
  input  logic [an-1:0]   enable,
  input  logic            clr_flags,
  pid_scheduler_if.master bus,
  output logic            busy,
  output logic            overrun,
  output logic [an-1:0]   timeout
);
  localparam int tw = $clog2(tmo + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_STEP = 3'd2;
  localparam logic [2:0] S_CAPT = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;

  logic [2:0]       fsm_q, fsm_d;
  logic [psc-1:0]   cnt_q, cnt_d;
  logic [an-1:0]    mask_q, mask_d;
  logic [aw-1:0]    a_q, a_d;
  logic [3:0]       st_q, st_d;
  logic             calc_q, calc_d;
  logic [sdw-1:0]   gap_q, gap_d;
  logic [tw-1:0]    tcnt_q, tcnt_d;
  logic [ew-1:0]    err_q, err_d;
  logic [an*ow-1:0] mout_q, mout_d;
  logic [an-1:0]    ov_q, ov_d;
  logic [an-1:0]    to_q, to_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;

  logic             tick;
  logic             ovr_set;
  logic [an-1:0]    to_set;
  logic [an-1:0]    src;
  logic             nxt_found;
  logic [aw-1:0]    nxt_ch;

  // Channel search: lowest enabled channel at tick, next higher latched channel otherwise
  always_comb begin
    src       = (fsm_q == S_IDLE) ? enable : mask_q;
    nxt_found = 1'b0;
    nxt_ch    = '0;
    for (int i = an - 1; i >= 0; i--) begin
      if (src[i] && ((fsm_q == S_IDLE) || (i > int'(a_q)))) begin
        nxt_found = 1'b1;
        nxt_ch    = aw'(i);
      end
    end
  end

  // Period counter, sweep FSM, capture registers and sticky flags
  always_comb begin
    fsm_d   = fsm_q;
    mask_d  = mask_q;
    a_d     = a_q;
    st_d    = st_q;
    calc_d  = 1'b0;
    gap_d   = gap_q;
    tcnt_d  = tcnt_q;
    err_d   = err_q;
    mout_d  = mout_q;
    busy_d  = busy_q;
    to_set  = '0;
    tick    = (cnt_q == period);
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    // a tick that lands inside a sweep is dropped
    ovr_set = tick & busy_q;
    ov_d    = ov_q & ~bus.out_ack;

    case (fsm_q)
      S_IDLE: begin
        if (tick && nxt_found) begin
          mask_d = enable;
          busy_d = 1'b1;
          a_d    = nxt_ch;
          tcnt_d = '0;
          fsm_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.err_valid) begin
          err_d  = bus.err_in;
          calc_d = 1'b1;
          st_d   = 4'd0;
          fsm_d  = S_STEP;
        end else if (tcnt_q == tw'(tmo - 1)) begin
          to_set[a_q] = 1'b1;
          fsm_d       = S_NEXT;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_STEP: begin
        // calc_q marks a strobe cycle; state advances only on the next strobe
        if (calc_q) begin
          if (st_q == 4'd8) begin
            fsm_d = S_CAPT;
          end else if (step_div == '0) begin
            calc_d = 1'b1;
            st_d   = st_q + 4'd1;
          end else begin
            gap_d = step_div;
          end
        end else begin
          gap_d = gap_q - 1'b1;
          if (gap_q == sdw'(1)) begin
            calc_d = 1'b1;
            st_d   = st_q + 4'd1;
          end
        end
      end
      S_CAPT: begin
        mout_d[int'(a_q)*ow +: ow] = bus.m_in;
        if (ov_q[a_q] && !bus.out_ack[a_q]) ovr_set = 1'b1;
        // capture beats a same-cycle ack
        ov_d[a_q] = 1'b1;
        fsm_d     = S_NEXT;
      end
      S_NEXT: begin
        if (nxt_found) begin
          a_d    = nxt_ch;
          tcnt_d = '0;
          fsm_d  = S_REQ;
        end else begin
          busy_d = 1'b0;
          a_d    = '0;
          st_d   = 4'd0;
          fsm_d  = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase

    // set events win over a simultaneous clear
    ovr_d = ovr_set | (ovr_q & ~clr_flags);
    to_d  = to_set | (to_q & ~{an{clr_flags}});
  end

  // State registers; reset aborts any sweep in flight
  always_ff @(posedge clk_pid or negedge reset) begin
    if (!reset) begin
      fsm_q  <= S_IDLE;
      cnt_q  <= '0;
      mask_q <= '0;
      a_q    <= '0;
      st_q   <= '0;
      calc_q <= 1'b0;
      gap_q  <= '0;
      tcnt_q <= '0;
      err_q  <= '0;
      mout_q <= '0;
      ov_q   <= '0;
      to_q   <= '0;
      busy_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
      a_q    <= a_d;
      st_q   <= st_d;
      calc_q <= calc_d;
      gap_q  <= gap_d;
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
      mout_q <= mout_d;
      ov_q   <= ov_d;
      to_q   <= to_d;
      busy_q <= busy_d;
      ovr_q  <= ovr_d;
    end
  end

  assign bus.err_req   = (fsm_q == S_REQ);
  assign bus.err_out   = err_q;
  assign bus.a         = a_q;
  assign bus.state     = st_q;
  assign bus.calc      = calc_q;
  assign bus.m_out     = mout_q;
  assign bus.out_valid = ov_q;
  assign busy          = busy_q;
  assign overrun       = ovr_q;
  assign timeout       = to_q;
endmodule

// File: tb/tb_pid_scheduler.sv
// Directed bench for pid_scheduler with a sweep-plan reference model.
// Latency: checks every clock at the falling edge.
// Backpressure: err_valid answered per channel from a table; acks driven directly.
module tb_pid_scheduler;
  localparam int AW = 1, AN = 2, PSC = 15, SDW = 8, EW = 24, OW = 12, TMO = 255;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [PSC-1:0] period = '0;
  logic [SDW-1:0] step_div = '0;
  logic [AN-1:0]  enable = '0;
  logic           clr_flags = 1'b0;
  logic           busy, overrun;
  logic [AN-1:0]  timeout;
  logic [AN-1:0]  ev_en = '1;

  int tests = 0;
  int fails = 0;
  int k = 0;

  pid_scheduler_if #(.aw(AW), .ew(EW), .ow(OW)) bus ();

  pid_scheduler #(.aw(AW), .an(AN), .psc(PSC), .sdw(SDW), .ew(EW), .ow(OW), .tmo(TMO)) dut (
    .clk_pid   (clk),
    .reset     (rst_n),
    .period    (period),
    .step_div  (step_div),
    .enable    (enable),
    .clr_flags (clr_flags),
    .bus       (bus),
    .busy      (busy),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // error source answers immediately for channels marked in ev_en, never otherwise
  assign bus.err_valid = ev_en[bus.a];

  // ---------------- reference model: one plan entry per clock of a sweep
  typedef struct packed {
    logic [AW-1:0] a;
    logic [3:0]    st;
    logic          calc;
    logic          req;
    logic          busy;
    logic          cap;
    logic          to;
    logic          lat;
  } ent_t;

  ent_t            plan[$];
  ent_t            cur = '0;
  int              mcnt = 0;
  logic [AN-1:0]   m_ov = '0;
  logic [AN-1:0]   m_to = '0;
  logic            m_ovr = 1'b0;
  logic [EW-1:0]   m_err = '0;
  logic [AN*OW-1:0] m_mout = '0;

  task automatic push(input int ch, input int st, input bit c, input bit r,
                      input bit cp, input bit t, input bit l);
    ent_t e;
    e.a = AW'(ch); e.st = 4'(st); e.calc = c; e.req = r; e.busy = 1'b1;
    e.cap = cp; e.to = t; e.lat = l;
    plan.push_back(e);
  endtask

  // whole sweep laid out clock by clock: REQ, 9 strobes with gaps, CAPT, NEXT per channel
  task automatic build_plan(input logic [AN-1:0] m, input int sd);
    int cs = 0;
    for (int ch = 0; ch < AN; ch++) begin
      if (m[ch]) begin
        if (ev_en[ch]) begin
          push(ch, cs, 0, 1, 0, 0, 1);
          for (int s = 0; s <= 8; s++) begin
            push(ch, s, 1, 0, 0, 0, 0);
            if (s < 8) for (int g = 0; g < sd; g++) push(ch, s, 0, 0, 0, 0, 0);
          end
          cs = 8;
          push(ch, cs, 0, 0, 1, 0, 0);
        end else begin
          for (int t = 0; t < TMO - 1; t++) push(ch, cs, 0, 1, 0, 0, 0);
          push(ch, cs, 0, 1, 0, 1, 0);
        end
        push(ch, cs, 0, 0, 0, 0, 0);
      end
    end
  endtask

  initial forever begin
    bit tk;
    bit ovr_set;
    logic [AN-1:0] to_set;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      plan.delete();
      cur = '0; mcnt = 0; m_ov = '0; m_to = '0; m_ovr = 1'b0; m_err = '0; m_mout = '0;
    end else begin
      tk      = (mcnt == int'(period));
      mcnt    = tk ? 0 : mcnt + 1;
      ovr_set = tk && cur.busy;
      to_set  = '0;
      if (tk && !cur.busy && enable != '0) build_plan(enable, int'(step_div));
      if (cur.lat) m_err = bus.err_in;
      if (cur.cap) begin
        if (m_ov[cur.a] && !bus.out_ack[cur.a]) ovr_set = 1'b1;
        m_mout[int'(cur.a)*OW +: OW] = bus.m_in;
        m_ov = m_ov & ~bus.out_ack;
        m_ov[cur.a] = 1'b1;
      end else begin
        m_ov = m_ov & ~bus.out_ack;
      end
      if (cur.to) to_set[cur.a] = 1'b1;
      m_ovr = ovr_set | (m_ovr & !clr_flags);
      m_to  = to_set | (m_to & {AN{!clr_flags}});
      cur   = (plan.size() > 0) ? plan.pop_front() : '0;
    end
  end

  // ---------------- checking
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, k, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("model_ctl", {bus.a, bus.state, bus.calc, bus.err_req, busy},
        {cur.a, cur.st, cur.calc, cur.req, cur.busy});
    chk("model_flags", {bus.out_valid, overrun, timeout}, {m_ov, m_ovr, m_to});
    chk("model_err_out", bus.err_out, m_err);
    chk("model_m_out", bus.m_out, m_mout);
  end

  // ---------------- stimulus helpers
  task automatic nstep();
    @(negedge clk);
    k++;
    bus.m_in    = OW'(k * 7 + 3);
    bus.out_ack = '0;
    clr_flags   = 1'b0;
  endtask

  task automatic run_to(input int n);
    while (k < n) nstep();
  endtask

  task automatic do_reset(input int per, input int sd, input logic [AN-1:0] en,
                          input logic [AN-1:0] ev);
    rst_n = 1'b0;
    period = PSC'(per); step_div = SDW'(sd); enable = en; ev_en = ev;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {bus.a, bus.state, bus.calc, bus.err_req, busy}, 8'd0);
    chk("rst_flags", {bus.out_valid, overrun, timeout}, 5'd0);
    chk("rst_data", {bus.err_out, bus.m_out}, 48'd0);
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic wait_req(input string name, input int exp_k);
    bit found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      nstep();
      found = bus.err_req;
    end
    chk(name, 64'(k), 64'(exp_k));
  endtask

  initial begin
    bus.err_in = '0; bus.m_in = '0; bus.out_ack = '0;

    // single channel, back-to-back strobes, err_in = -5
    do_reset(99, 0, 2'b01, 2'b11);
    bus.err_in = 24'hFFFFFB;
    wait_req("s1_first_req", 100);
    run_to(101);
    chk("s1_strobe0", {bus.calc, bus.state}, {1'b1, 4'd0});
    chk("s1_err_out", bus.err_out, 24'hFFFFFB);
    run_to(109);
    chk("s1_strobe8", {bus.calc, bus.state}, {1'b1, 4'd8});
    run_to(110);
    chk("s1_capt_nocalc", bus.calc, 1'b0);
    run_to(111);
    chk("s1_m_out0", bus.m_out[OW-1:0], 12'd773);
    chk("s1_out_valid", bus.out_valid, 2'b01);
    run_to(112);
    chk("s1_busy_low", busy, 1'b0);
    run_to(200);
    chk("s1_second_sweep", bus.err_req, 1'b1);
    run_to(211);
    chk("s1_overrun_noack", overrun, 1'b1);
    run_to(220);
    clr_flags = 1'b1;
    run_to(221);
    chk("s1_clr_flags", overrun, 1'b0);
    run_to(310);
    bus.out_ack = 2'b01;
    run_to(311);
    chk("s1_ack_vs_capt", {bus.out_valid, overrun}, {2'b01, 1'b0});
    chk("s1_m_out0_3rd", bus.m_out[OW-1:0], 12'd2173);
    bus.out_ack = 2'b01;
    run_to(312);
    chk("s1_ack_clears", bus.out_valid, 2'b00);
    run_to(330);

    // two channels, step_div = 3
    do_reset(99, 3, 2'b11, 2'b11);
    bus.err_in = 24'h000123;
    run_to(105);
    chk("s2_ch0_strobe1", {bus.a, bus.calc, bus.state}, {1'b0, 1'b1, 4'd1});
    run_to(106);
    chk("s2_state_holds", {bus.calc, bus.state}, {1'b0, 4'd1});
    run_to(133);
    chk("s2_ch0_strobe8", {bus.a, bus.calc, bus.state}, {1'b0, 1'b1, 4'd8});
    run_to(136);
    chk("s2_ch1_req", {bus.a, bus.err_req}, {1'b1, 1'b1});
    run_to(137);
    chk("s2_ch1_strobe0", {bus.a, bus.calc, bus.state}, {1'b1, 1'b1, 4'd0});
    run_to(171);
    chk("s2_busy_in_next", busy, 1'b1);
    run_to(172);
    chk("s2_sweep_done", {busy, bus.out_valid, bus.a, bus.state}, {1'b0, 2'b11, 1'b0, 4'd0});

    // reset asserted during channel 1 STEP
    do_reset(99, 3, 2'b11, 2'b11);
    run_to(150);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_reset_ctl", {bus.calc, bus.err_req, busy, bus.a, bus.state}, 8'd0);
    chk("s5_reset_valid", bus.out_valid, 2'b00);
    do_reset(99, 3, 2'b11, 2'b11);
    wait_req("s5_first_req_after_reset", 100);

    // channel 0 error never arrives
    do_reset(299, 0, 2'b11, 2'b10);
    run_to(554);
    chk("s3_last_req_clock", {timeout, bus.err_req, bus.a}, {2'b00, 1'b1, 1'b0});
    run_to(555);
    chk("s3_timeout_set", {timeout, bus.err_req}, {2'b01, 1'b0});
    run_to(557);
    chk("s3_ch1_strobe0", {bus.a, bus.calc, bus.state}, {1'b1, 1'b1, 4'd0});
    run_to(568);
    chk("s3_only_ch1_valid", {busy, bus.out_valid}, {1'b0, 2'b10});
    run_to(570);
    clr_flags = 1'b1;
    run_to(571);
    chk("s3_timeout_clr", timeout, 2'b00);

    // short period: ticks land inside the sweep
    do_reset(10, 0, 2'b11, 2'b11);
    run_to(21);
    chk("s4_no_overrun_yet", overrun, 1'b0);
    run_to(22);
    chk("s4_overrun", overrun, 1'b1);
    run_to(35);
    chk("s4_sweep_done", busy, 1'b0);
    run_to(43);
    chk("s4_idle_wait", {bus.err_req, busy}, 2'b00);
    run_to(44);
    chk("s4_next_sweep", {bus.err_req, bus.a}, {1'b1, 1'b0});
    run_to(80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pid_scheduler.md
Name: pid_scheduler

Overview:
- Sequencer and time-multiplexer for the shared multi-channel PID datapath.
- Replaces the free-running prescaler: generates the loop-period tick, then walks each enabled channel through datapath states 0..8 with single-cycle calc strobes.
- Fetches each channel's error sample through a req/valid handshake, latches it for the datapath, and captures the scaled motor output into per-channel registers with a valid/ack handshake.
- Sits between the encoder/setpoint logic and the PID datapath; the CPU configures it through the SoC register file.

Parameters:
aw, 1, channel address width
an, 2**aw, number of channels
psc, 15, period counter width
sdw, 8, step divider width
ew, 24, error width
ow, 12, output width
tmo, 255, error-handshake timeout in clocks

Ports:
clk_pid  in  1  PID clock
reset  in  1  asynchronous, active-low reset
period  in  psc  loop period; tick every period+1 clocks
step_div  in  sdw  idle clocks between calc strobes
enable  in  an  per-channel enable mask, sampled at tick
clr_flags  in  1  one-cycle pulse, clears sticky flags
err_req  out  1  error sample request for channel a
err_valid  in  1  error sample present on err_in
err_in  in  ew  signed error sample
err_out  out  ew  latched error to datapath
a  out  aw  datapath channel address
state  out  4  datapath state code
calc  out  1  one-cycle datapath step strobe
m_in  in  ow  datapath scaled output for channel a
m_out  out  an*ow  captured outputs; channel i at [i*ow +: ow]
out_valid  out  an  capture pending per channel
out_ack  in  an  per-channel consume pulse
busy  out  1  sweep in progress
overrun  out  1  sticky: tick arrived while busy
timeout  out  an  sticky: err_valid not seen within tmo

Behaviour:
- Reset (reset=0, asynchronous) clears all outputs, period counter, FSM, err_out, m_out and every flag. A reset mid-sweep aborts it; no partial capture occurs.
- Period counter counts 0..period, then wraps to 0. Tick = the cycle the counter equals period. period=0 gives a tick every clock.
- FSM states: IDLE, REQ, STEP, CAPT, NEXT.
- IDLE:
  - On tick: latch enable into an internal mask and set busy.
  - Go to REQ for the lowest enabled channel; if the mask is 0, stay IDLE and leave busy at 0.
- REQ:
  - a = channel; err_req=1; timeout counter starts at 0.
  - On a cycle with err_valid=1: err_out <= err_in, err_req drops, go to STEP.
  - If tmo clocks pass without err_valid: set timeout[ch], drop err_req, go to NEXT. No calcs are issued and no capture occurs for that channel.
- STEP:
  - Issues state codes 0..8 in order, each with calc=1 for exactly one cycle; state holds between strobes.
  - The first strobe is the cycle after leaving REQ; consecutive strobes are step_div+1 clocks apart.
  - After the state-8 strobe, go to CAPT on the next cycle.
- CAPT (one cycle):
  - m_out[ch] <= m_in; out_valid[ch] <= 1.
  - If out_valid[ch] was already 1 and out_ack[ch] is not asserted, set overrun as well.
- NEXT: select the next higher enabled channel and go to REQ; if none remains, clear busy, set a=0 and state=0, go to IDLE.
- Tick while busy: the tick is dropped and overrun is set. The period counter keeps running.
- out_ack[i] clears out_valid[i]. Ack in the same cycle as a capture of the same channel: capture wins, out_valid stays 1, overrun is not set.
- clr_flags clears overrun and timeout. A simultaneous flag-set event takes priority.
- enable changes mid-sweep have no effect until the next tick.
- a, state and err_out are stable between strobes. calc is 0 in every state except STEP strobe cycles.

Test Plan:
- period=99, step_div=0, enable=01, err_valid tied 1, err_in=-5, tick at cycle T:
  - err_req=1 at T+1;
  - calc strobes at T+2..T+10 with state 0..8;
  - err_out=-5 from T+2;
  - m_out[0]=m_in and out_valid[0]=1 visible at T+12;
  - next sweep at T+100.
- enable=11, step_div=3: channel 0 strobes 4 clocks apart, then channel 1 runs with a=1; busy falls after channel 1 CAPT; both out_valid=1.
- No out_ack across two sweeps -> overrun=1 after the second capture; out_ack[0] together with a capture -> out_valid stays 1, no overrun; clr_flags -> overrun=0.
- err_valid held 0, tmo=255 -> timeout[0]=1 after 255 REQ clocks; no calc for channel 0; channel 1 still serviced.
- period=10, enable=11, step_div=0 -> tick during sweep sets overrun; sweep completes normally; next sweep starts on the first tick after IDLE.
- reset=0 during STEP of channel 1 -> calc, err_req, busy, a, state, out_valid all 0 immediately; after release the first sweep starts at tick period+1 clocks later.
